// File: rtl/keyboard_entry_ctrl.sv
// keyboard_entry_ctrl: PS/2 scan-code decoder feeding a BCD cook-time entry.
// One clock domain; every output is registered one cycle after key_valid.
module keyboard_entry_ctrl #(
    parameter int NUM_DIGITS        = 4,
    parameter bit ENTER_NEEDS_DIGIT = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    key_valid,
    input  logic [7:0]              key_code,
    input  logic [1:0]              mode,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [3:0]              digit_count,
    output logic                    enter_pulse,
    output logic [2:0]              auto_mode,
    output logic                    auto_valid,
    output logic                    key_error
);

    localparam int         W        = 4 * NUM_DIGITS;
    localparam logic [3:0] MaxCount = 4'(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BREAK,
        EXT_BREAK
    } decState_t;

    decState_t         decState;
    decState_t         decStateNext;
    logic              isMake;
    logic              isExt;
    logic              keyNormal;
    logic [4:0]        digitHit;
    logic [3:0]        autoHit;
    logic [W-1:0]      digitsNext;
    logic [3:0]        countNext;
    logic              enterNext;
    logic              errorNext;
    logic [2:0]        autoModeNext;
    logic              autoValidNext;

    // Bit 4 flags a digit key; keypad and top row map to the same value.
    function automatic logic [4:0] decodeDigit(input logic [7:0] code);
        case (code)
            8'h70, 8'h45: decodeDigit = 5'h10;
            8'h69, 8'h16: decodeDigit = 5'h11;
            8'h72, 8'h1E: decodeDigit = 5'h12;
            8'h7A, 8'h26: decodeDigit = 5'h13;
            8'h6B, 8'h25: decodeDigit = 5'h14;
            8'h73, 8'h2E: decodeDigit = 5'h15;
            8'h74, 8'h36: decodeDigit = 5'h16;
            8'h6C, 8'h3D: decodeDigit = 5'h17;
            8'h75, 8'h3E: decodeDigit = 5'h18;
            8'h7D, 8'h46: decodeDigit = 5'h19;
            default:      decodeDigit = 5'h00;
        endcase
    endfunction

    function automatic logic [3:0] decodeAuto(input logic [7:0] code);
        case (code)
            8'h4D:   decodeAuto = 4'h8;
            8'h44:   decodeAuto = 4'h9;
            8'h3A:   decodeAuto = 4'hA;
            8'h2A:   decodeAuto = 4'hB;
            8'h32:   decodeAuto = 4'hC;
            8'h2D:   decodeAuto = 4'hD;
            8'h23:   decodeAuto = 4'hE;
            8'h1C:   decodeAuto = 4'hF;
            default: decodeAuto = 4'h0;
        endcase
    endfunction

    assign digitHit  = decodeDigit(key_code);
    assign autoHit   = decodeAuto(key_code);
    assign keyNormal = isMake & ~isExt;

    always_comb begin
        decStateNext = decState;
        isMake       = 1'b0;
        isExt        = 1'b0;
        if (key_valid) begin
            unique case (decState)
                IDLE: begin
                    if (key_code == 8'hE0)      decStateNext = EXT;
                    else if (key_code == 8'hF0) decStateNext = BREAK;
                    else                        isMake = 1'b1;
                end
                EXT: begin
                    if (key_code == 8'hF0) begin
                        decStateNext = EXT_BREAK;
                    end else begin
                        isMake       = 1'b1;
                        isExt        = 1'b1;
                        decStateNext = IDLE;
                    end
                end
                default: decStateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        digitsNext    = digits;
        countNext     = digit_count;
        enterNext     = 1'b0;
        errorNext     = 1'b0;
        autoModeNext  = auto_mode;
        autoValidNext = auto_valid & (mode == 2'b10);
        if (isMake) begin
            unique case (mode)
                2'b01: begin
                    if (keyNormal && digitHit[4]) begin
                        // A simultaneous clear swallows the digit silently.
                        if (!clear) begin
                            if (digit_count == MaxCount) begin
                                errorNext = 1'b1;
                            end else begin
                                digitsNext = (digits << 4) | W'(digitHit[3:0]);
                                countNext  = digit_count + 4'd1;
                            end
                        end
                    end else if (keyNormal && key_code == 8'h66) begin
                        if (digit_count != 4'd0) begin
                            digitsNext = digits >> 4;
                            countNext  = digit_count - 4'd1;
                        end
                    end else if (keyNormal && key_code == 8'h76) begin
                        digitsNext = '0;
                        countNext  = 4'd0;
                    end else if (key_code == 8'h5A) begin
                        if (ENTER_NEEDS_DIGIT && digit_count == 4'd0)
                            errorNext = 1'b1;
                        else
                            enterNext = 1'b1;
                    end else begin
                        errorNext = 1'b1;
                    end
                end
                2'b10: begin
                    if (keyNormal && autoHit[3]) begin
                        autoModeNext  = autoHit[2:0];
                        autoValidNext = 1'b1;
                    end else begin
                        errorNext     = 1'b1;
                        autoModeNext  = 3'b000;
                        autoValidNext = 1'b0;
                    end
                end
                2'b11: enterNext = (key_code == 8'h5A);
                default: ;
            endcase
        end
        if (clear) begin
            digitsNext = '0;
            countNext  = 4'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            decState    <= IDLE;
            digits      <= '0;
            digit_count <= 4'd0;
            enter_pulse <= 1'b0;
            key_error   <= 1'b0;
            auto_mode   <= 3'b000;
            auto_valid  <= 1'b0;
        end else begin
            decState    <= decStateNext;
            digits      <= digitsNext;
            digit_count <= countNext;
            enter_pulse <= enterNext;
            key_error   <= errorNext;
            auto_mode   <= autoModeNext;
            auto_valid  <= autoValidNext;
        end
    end

endmodule

// File: tb/tb_keyboard_entry_ctrl.sv
// Scoreboard bench for keyboard_entry_ctrl: directed plan then random traffic,
// expectations from a queue-based key-entry model.
module tb_keyboard_entry_ctrl;

    localparam int ND = 4;

    logic            clock     = 1'b0;
    logic            reset     = 1'b0;
    logic            key_valid = 1'b0;
    logic [7:0]      key_code  = 8'h00;
    logic [1:0]      mode      = 2'b00;
    logic            clear     = 1'b0;
    logic [4*ND-1:0] digits;
    logic [3:0]      digit_count;
    logic            enter_pulse;
    logic [2:0]      auto_mode;
    logic            auto_valid;
    logic            key_error;

    keyboard_entry_ctrl #(.NUM_DIGITS(ND), .ENTER_NEEDS_DIGIT(1'b1)) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid),
        .key_code(key_code), .mode(mode), .clear(clear),
        .digits(digits), .digit_count(digit_count),
        .enter_pulse(enter_pulse), .auto_mode(auto_mode),
        .auto_valid(auto_valid), .key_error(key_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  cnt;
        logic        ent;
        logic [2:0]  am;
        logic        av;
        logic        err;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;

    // Model state: digits oldest-first, prefix bytes still pending.
    int         digQ[$];
    int         mAutoMode  = 0;
    bit         mAutoValid = 0;
    logic [7:0] pend[$];

    logic [7:0] kpTab[10]  = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                               8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    logic [7:0] topTab[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                               8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] autoTab[8] = '{8'h4D, 8'h44, 8'h3A, 8'h2A,
                               8'h32, 8'h2D, 8'h23, 8'h1C};

    function automatic int digitOf(input logic [7:0] c);
        for (int i = 0; i < 10; i++)
            if (kpTab[i] == c || topTab[i] == c) return i;
        return -1;
    endfunction

    function automatic int autoOf(input logic [7:0] c);
        for (int i = 0; i < 8; i++)
            if (autoTab[i] == c) return i;
        return -1;
    endfunction

    function automatic exp_t snap(input bit en, input bit er);
        exp_t e;
        e.dig = '0;
        for (int i = 0; i < digQ.size(); i++)
            e.dig[4*i +: 4] = 4'(digQ[digQ.size() - 1 - i]);
        e.cnt = 4'(digQ.size());
        e.ent = en;
        e.am  = 3'(mAutoMode);
        e.av  = mAutoValid;
        e.err = er;
        return e;
    endfunction

    task automatic modelStep(input bit kv, input logic [7:0] c,
                             input logic [1:0] m, input bit clr);
        bit en = 0;
        bit er = 0;
        bit mk = 0;
        bit ext = 0;
        int dv;
        int av;
        if (m != 2'b10) mAutoValid = 0;
        if (kv) begin
            if (pend.size() > 0 && pend[$] == 8'hF0) begin
                pend.delete();
            end else if (c == 8'hF0) begin
                pend.push_back(c);
            end else if (c == 8'hE0 && pend.size() == 0) begin
                pend.push_back(c);
            end else begin
                mk  = 1;
                ext = (pend.size() > 0);
                pend.delete();
            end
        end
        dv = ext ? -1 : digitOf(c);
        av = ext ? -1 : autoOf(c);
        if (mk) begin
            case (m)
                2'b01: begin
                    if (dv >= 0) begin
                        if (!clr) begin
                            if (digQ.size() == ND) er = 1;
                            else digQ.push_back(dv);
                        end
                    end else if (!ext && c == 8'h66) begin
                        if (digQ.size() > 0) void'(digQ.pop_back());
                    end else if (!ext && c == 8'h76) begin
                        digQ.delete();
                    end else if (c == 8'h5A) begin
                        if (digQ.size() == 0) er = 1;
                        else en = 1;
                    end else begin
                        er = 1;
                    end
                end
                2'b10: begin
                    if (av >= 0) begin
                        mAutoMode  = av;
                        mAutoValid = 1;
                    end else begin
                        er         = 1;
                        mAutoMode  = 0;
                        mAutoValid = 0;
                    end
                end
                2'b11: en = (c == 8'h5A);
                default: ;
            endcase
        end
        if (clr) digQ.delete();
        expQ.push_back(snap(en, er));
    endtask

    task automatic step(input bit kv, input logic [7:0] c,
                        input logic [1:0] m, input bit clr);
        @(negedge clock);
        reset     = 1'b1;
        key_valid = kv;
        key_code  = c;
        mode      = m;
        clear     = clr;
        modelStep(kv, c, m, clr);
    endtask

    task automatic key(input logic [7:0] c, input logic [1:0] m);
        step(1'b1, c, m, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset     = 1'b0;
        key_valid = 1'b0;
        clear     = 1'b0;
        digQ.delete();
        pend.delete();
        mAutoMode  = 0;
        mAutoValid = 0;
        expQ.push_back(snap(0, 0));
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                cur = expQ.pop_front();
                chk("digits",      int'(digits),      int'(cur.dig));
                chk("digit_count", int'(digit_count), int'(cur.cnt));
                chk("enter_pulse", int'(enter_pulse), int'(cur.ent));
                chk("auto_mode",   int'(auto_mode),   int'(cur.am));
                chk("auto_valid",  int'(auto_valid),  int'(cur.av));
                chk("key_error",   int'(key_error),   int'(cur.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rm;
        logic [7:0] seq[$];
        int         r;
        doReset();
        // Make/break pairs
        key(8'h69, 2'b01); key(8'hF0, 2'b01); key(8'h69, 2'b01);
        key(8'h72, 2'b01); key(8'hF0, 2'b01); key(8'h72, 2'b01);
        step(0, 8'h00, 2'b01, 0);
        // Full buffer then backspace
        key(8'h76, 2'b01);
        key(8'h16, 2'b01); key(8'h1E, 2'b01); key(8'h26, 2'b01);
        key(8'h25, 2'b01); key(8'h2E, 2'b01);
        key(8'h66, 2'b01);
        step(0, 8'h00, 2'b01, 0);
        // Enter on empty buffer, then extended enter
        key(8'h76, 2'b01);
        key(8'h5A, 2'b01);
        key(8'h70, 2'b01); key(8'hE0, 2'b01); key(8'h5A, 2'b01);
        step(0, 8'h00, 2'b01, 0);
        // Auto selection
        key(8'h3A, 2'b10); key(8'h15, 2'b10); key(8'h1C, 2'b10);
        step(0, 8'h00, 2'b00, 0);
        step(0, 8'h00, 2'b00, 0);
        // Clear racing a digit
        key(8'h69, 2'b01);
        step(1, 8'h7D, 2'b01, 1);
        step(0, 8'h00, 2'b01, 0);
        // Reset in the middle of a break sequence
        key(8'hF0, 2'b01);
        doReset();
        key(8'h69, 2'b01);
        step(0, 8'h00, 2'b01, 0);
        // Confirm mode and ignore mode
        key(8'h5A, 2'b11); key(8'h15, 2'b11); key(8'h16, 2'b00);

        rm = 2'b01;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) rm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) doReset();
            seq.delete();
            r = $urandom_range(0, 11);
            case (r)
                0, 1: seq.push_back(kpTab[$urandom_range(0, 9)]);
                2, 3: seq.push_back(topTab[$urandom_range(0, 9)]);
                4: begin
                    seq.push_back(8'hF0);
                    seq.push_back(topTab[$urandom_range(0, 9)]);
                end
                5: begin seq.push_back(8'hE0); seq.push_back(8'h5A); end
                6: seq.push_back(8'h66);
                7: seq.push_back(autoTab[$urandom_range(0, 7)]);
                8: seq.push_back(8'($urandom_range(0, 255)));
                9: begin
                    seq.push_back(8'hE0); seq.push_back(8'hF0);
                    seq.push_back(8'h5A);
                end
                10: seq.push_back(8'h5A);
                default: seq.push_back(8'h76);
            endcase
            foreach (seq[i])
                step(1, seq[i], rm, ($urandom_range(0, 29) == 0));
            if ($urandom_range(0, 2) == 0)
                step(0, 8'h00, rm, ($urandom_range(0, 29) == 0));
        end

        step(0, 8'h00, 2'b00, 0);
        @(negedge clock);
        @(negedge clock);
        chk("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
